// File: rtl/sub_pkg.sv
// Shared types for the subtractor flag stage: condition codes, flag bundle and
// the condition evaluator used by branch/compare consumers.
package sub_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    // Bit order {n,z,c,v} matches the external 4-bit flag buses.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    function automatic logic cond_eval(input cond_e sel, input flags_t f);
        logic r;
        r = 1'b0;
        case (sel)
            COND_EQ: r = f.z;
            COND_NE: r = ~f.z;
            COND_CS: r = f.c;
            COND_CC: r = ~f.c;
            COND_MI: r = f.n;
            COND_PL: r = ~f.n;
            COND_VS: r = f.v;
            COND_VC: r = ~f.v;
            COND_HI: r = f.c & ~f.z;
            COND_LS: r = ~f.c | f.z;
            COND_GE: r = (f.n == f.v);
            COND_LT: r = (f.n != f.v);
            COND_GT: r = ~f.z & (f.n == f.v);
            COND_LE: r = f.z | (f.n != f.v);
            COND_AL: r = 1'b1;
            COND_NV: r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sub_flags_stage_fifo2.sv
// Two-entry in-order valid/ready buffer. Head is a register driven straight
// to the outputs; in_ready depends only on the registered count.
module sync_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [1:0]   r_count;
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic         w_push;
    logic         w_pop;

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_head;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= in_data;
                    else                 r_tail <= in_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                // Simultaneous push/pop only happens at count 1: new entry becomes head.
                2'b11: r_head <= in_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sub_flags_stage.sv
// Registered output stage after the subtractor: buffers result+flags, tracks
// the architectural status flags, sticky overflow and accepted-op count.
module sub_flags_stage
    import sub_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_result,
    input  logic             in_neg,
    input  logic             in_zr,
    input  logic             in_cry,
    input  logic             in_of,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_result,
    output logic [3:0]       out_flags,
    input  logic [3:0]       cond_sel,
    output logic             cond_true,
    output logic [3:0]       status,
    output logic             sticky_of,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] op_count
);

    flags_t             w_in_flags;
    logic               w_push;
    logic [N+3:0]       w_out_data;
    flags_t             r_status;
    logic               r_sticky;
    logic [CNT_W-1:0]   r_count;

    assign w_in_flags = '{n: in_neg, z: in_zr, c: in_cry, v: in_of};
    assign w_push     = in_valid & in_ready;

    sync_fifo2 #(.W(N + 4)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_result, w_in_flags}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_data)
    );

    assign out_result = w_out_data[N+3:4];
    assign out_flags  = w_out_data[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status <= '0;
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_status <= w_in_flags;
                r_count  <= r_count + 1'b1;
            end
            // A new overflow outranks a same-cycle clear.
            if (w_push && in_of) r_sticky <= 1'b1;
            else if (clr_sticky) r_sticky <= 1'b0;
        end
    end

    assign status    = r_status;
    assign sticky_of = r_sticky;
    assign op_count  = r_count;
    assign cond_true = cond_eval(cond_e'(cond_sel), r_status);

endmodule

// File: tb/tb_sub_flags_stage.sv
// Directed bench for sub_flags_stage: condition-code table plus handshake,
// sticky, reset and counter-wrap sequences.
module tb_sub_flags_stage;
    import sub_pkg::*;

    localparam int N     = 4;
    localparam int CNT_W = 16;

    logic             clk, rst_n;
    logic             in_valid, in_ready;
    logic [N-1:0]     in_result;
    logic             in_neg, in_zr, in_cry, in_of;
    logic             out_valid, out_ready;
    logic [N-1:0]     out_result;
    logic [3:0]       out_flags;
    logic [3:0]       cond_sel;
    logic             cond_true;
    logic [3:0]       status;
    logic             sticky_of, clr_sticky;
    logic [CNT_W-1:0] op_count;

    sub_flags_stage #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_neg(in_neg), .in_zr(in_zr), .in_cry(in_cry), .in_of(in_of),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags),
        .cond_sel(cond_sel), .cond_true(cond_true), .status(status),
        .sticky_of(sticky_of), .clr_sticky(clr_sticky), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt;

    typedef struct {
        logic [3:0] flags;
        logic [3:0] sel;
        logic       exp;
    } cv_t;
    cv_t cv[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] r, input logic [3:0] f);
        in_valid  = v;
        in_result = r;
        {in_neg, in_zr, in_cry, in_of} = f;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        // {flags nzcv, cond_sel, expected cond_true}
        cv[0]  = '{4'b0100, 4'h0, 1'b1};
        cv[1]  = '{4'b0100, 4'h1, 1'b0};
        cv[2]  = '{4'b0010, 4'h2, 1'b1};
        cv[3]  = '{4'b0010, 4'h3, 1'b0};
        cv[4]  = '{4'b1000, 4'h4, 1'b1};
        cv[5]  = '{4'b1000, 4'h5, 1'b0};
        cv[6]  = '{4'b0001, 4'h6, 1'b1};
        cv[7]  = '{4'b0000, 4'h7, 1'b1};
        cv[8]  = '{4'b0010, 4'h8, 1'b1};
        cv[9]  = '{4'b0110, 4'h8, 1'b0};
        cv[10] = '{4'b0110, 4'h9, 1'b1};
        cv[11] = '{4'b0010, 4'h9, 1'b0};
        cv[12] = '{4'b1001, 4'hA, 1'b1};
        cv[13] = '{4'b1000, 4'hA, 1'b0};
        cv[14] = '{4'b0001, 4'hB, 1'b1};
        cv[15] = '{4'b0000, 4'hC, 1'b1};
        cv[16] = '{4'b0100, 4'hC, 1'b0};
        cv[17] = '{4'b1000, 4'hD, 1'b1};
        cv[18] = '{4'b0000, 4'hD, 1'b0};
        cv[19] = '{4'b0000, 4'hE, 1'b1};
        cv[20] = '{4'b1111, 4'hF, 1'b0};

        rst_n = 1'b0; drive(1'b0, 4'h0, 4'h0);
        out_ready = 1'b0; clr_sticky = 1'b0; cond_sel = 4'hE;
        exp_cnt = '0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready",  32'(in_ready), 1);
        chk("rst_status",    32'(status), 0);
        chk("rst_op_count",  32'(op_count), 0);
        chk("rst_sticky",    32'(sticky_of), 0);
        chk("rst_out_res",   32'(out_result), 0);
        chk("rst_out_flags", 32'(out_flags), 0);
        chk("rst_cond_al",   32'(cond_true), 1);
        rst_n = 1'b1;
        tick();

        // Single push, head appears next cycle
        out_ready = 1'b1;
        drive(1'b1, 4'hD, 4'b1011);
        tick(); exp_cnt++;
        drive(1'b0, 4'h0, 4'h0);
        cond_sel = 4'hB;
        #1;
        chk("p1_out_valid", 32'(out_valid), 1);
        chk("p1_out_res",   32'(out_result), 32'hD);
        chk("p1_out_flags", 32'(out_flags), 32'b1011);
        chk("p1_status",    32'(status), 32'b1011);
        chk("p1_sticky",    32'(sticky_of), 1);
        chk("p1_cond_lt",   32'(cond_true), 0);
        chk("p1_op_count",  32'(op_count), 32'(exp_cnt));
        tick();
        chk("p1_drained", 32'(out_valid), 0);

        // Backpressure: fill two, third waits, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 4'h1, 4'b0000); tick(); exp_cnt++;
        drive(1'b1, 4'h2, 4'b0000); tick(); exp_cnt++;
        drive(1'b1, 4'h3, 4'b0000);
        #1;
        chk("bp_in_ready_full", 32'(in_ready), 0);
        chk("bp_head1", 32'(out_result), 1);
        tick();
        chk("bp_head1_held", 32'(out_result), 1);
        chk("bp_cnt_held", 32'(op_count), 32'(exp_cnt));
        out_ready = 1'b1;
        #1;
        chk("bp_drain_1", 32'(out_result), 1);
        tick();
        chk("bp_drain_2", 32'(out_result), 2);
        chk("bp_ready_again", 32'(in_ready), 1);
        tick(); exp_cnt++;
        drive(1'b0, 4'h0, 4'h0);
        chk("bp_drain_3", 32'(out_result), 3);
        chk("bp_valid_3", 32'(out_valid), 1);
        tick();
        chk("bp_empty", 32'(out_valid), 0);
        chk("bp_op_count", 32'(op_count), 32'(exp_cnt));

        // Push and pop together at count 1
        out_ready = 1'b0;
        drive(1'b1, 4'h9, 4'b0000); tick(); exp_cnt++;
        out_ready = 1'b1;
        drive(1'b1, 4'h5, 4'b0000); tick(); exp_cnt++;
        drive(1'b0, 4'h0, 4'h0);
        out_ready = 1'b0;
        #1;
        chk("pp_head5", 32'(out_result), 5);
        chk("pp_in_ready", 32'(in_ready), 1);
        chk("pp_op_count", 32'(op_count), 32'(exp_cnt));
        out_ready = 1'b1;
        tick();
        chk("pp_count_was1", 32'(out_valid), 0);

        // Condition-code table
        for (int i = 0; i < 21; i++) begin
            drive(1'b1, 4'(i), cv[i].flags);
            tick(); exp_cnt++;
            drive(1'b0, 4'h0, 4'h0);
            cond_sel = cv[i].sel;
            #1;
            chk($sformatf("cv%0d_cond", i), 32'(cond_true), 32'(cv[i].exp));
            chk($sformatf("cv%0d_flags", i), 32'(out_flags), 32'(cv[i].flags));
            tick();
        end
        chk("cv_op_count", 32'(op_count), 32'(exp_cnt));
        chk("cv_status_hold", 32'(status), 32'b1111);

        // Sticky: set beats clear, clear alone works
        clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
        chk("st_cleared", 32'(sticky_of), 0);
        clr_sticky = 1'b1;
        drive(1'b1, 4'h7, 4'b0001); tick(); exp_cnt++;
        drive(1'b0, 4'h0, 4'h0); clr_sticky = 1'b0;
        chk("st_set_wins", 32'(sticky_of), 1);
        tick();
        chk("st_holds", 32'(sticky_of), 1);
        clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
        chk("st_clr_alone", 32'(sticky_of), 0);
        drive(1'b1, 4'h7, 4'b0000); tick(); exp_cnt++;
        drive(1'b0, 4'h0, 4'h0);
        chk("st_no_v", 32'(sticky_of), 0);
        tick();

        // Async reset while full
        out_ready = 1'b0;
        drive(1'b1, 4'hA, 4'b1001); tick();
        drive(1'b1, 4'hB, 4'b1001); tick();
        drive(1'b0, 4'h0, 4'h0);
        chk("mr_full", 32'(in_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", 32'(out_valid), 0);
        chk("mr_in_ready",  32'(in_ready), 1);
        chk("mr_status",    32'(status), 0);
        chk("mr_sticky",    32'(sticky_of), 0);
        chk("mr_op_count",  32'(op_count), 0);
        chk("mr_out_res",   32'(out_result), 0);
        chk("mr_out_flags", 32'(out_flags), 0);
        rst_n = 1'b1;
        tick();

        // Counter wrap
        exp_cnt = '0;
        out_ready = 1'b1;
        drive(1'b1, 4'h1, 4'b0000);
        repeat (65535) begin
            tick(); exp_cnt++;
        end
        chk("wrap_ffff", 32'(op_count), 32'hFFFF);
        tick(); exp_cnt++;
        chk("wrap_zero", 32'(op_count), 32'(exp_cnt));
        drive(1'b0, 4'h0, 4'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
